// File: rtl/hard_mem_req_pkg.sv
// Shared types and constants for the hard-macro 1RW requester.
// Imported by the requester top and its response FIFO.
package hard_mem_req_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int RESP_FIFO_DEPTH = 2;
    localparam int CNT_W = $clog2(RESP_FIFO_DEPTH + 1);

endpackage

// File: rtl/hard_mem_resp_fifo.sv
// Two-entry read-response FIFO; output driven straight from the head register.
// Head data only changes on a pop or on a push into an empty FIFO.
module hard_mem_resp_fifo
    import hard_mem_req_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_v,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_v,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(RESP_FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [DW-1:0]    head;
    logic [DW-1:0]    tail;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    assign out_v    = (cnt != '0);
    assign out_data = head;
    assign count    = cnt;
    assign pop      = out_v & out_ready;
    // A simultaneous pop frees a slot, so a full FIFO can still take data.
    assign in_ready = (cnt < FULL) | out_ready;
    assign push     = in_v & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (cnt == '0) begin
                        head <= in_data;
                    end else begin
                        tail <= in_data;
                    end
                    cnt <= cnt + ONE;
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - ONE;
                end
                2'b11: begin
                    if (cnt == ONE) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/hard_mem_1rw_requester.sv
// Requester in front of a 1RW hard memory: zero-sweep init, command
// pass-through and credit-limited in-order read responses.
module hard_mem_1rw_requester
    import hard_mem_req_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 9
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            cmd_v_i,
    output logic            cmd_ready_o,
    input  logic            cmd_w_i,
    input  logic [AW-1:0]   cmd_addr_i,
    input  logic [DW-1:0]   cmd_data_i,
    input  logic [DW/8-1:0] cmd_mask_i,
    output logic            resp_v_o,
    input  logic            resp_ready_i,
    output logic [DW-1:0]   resp_data_o,
    output logic            mem_v_o,
    output logic            mem_w_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_data_o,
    output logic [DW/8-1:0] mem_w_mask_o,
    input  logic [DW-1:0]   mem_data_i,
    input  logic            init_i,
    output logic            init_done_o
);

    localparam int OCC_W = CNT_W + 1;
    localparam logic [AW-1:0] SWEEP_LAST = '1;
    localparam logic [OCC_W-1:0] CREDITS = OCC_W'(RESP_FIFO_DEPTH);

    state_e           state;
    state_e           state_nxt;
    logic [AW-1:0]    sweep;
    logic [AW-1:0]    sweep_nxt;
    logic             rd_inflight;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_in_ready;
    logic             resp_pop;
    logic [OCC_W-1:0] occ;
    logic             accept;

    assign resp_pop = resp_v_o & resp_ready_i;

    // Outstanding reads after this cycle's pop; a new read needs a free slot.
    assign occ = OCC_W'(fifo_cnt)
               + OCC_W'(rd_inflight)
               - OCC_W'(resp_pop);

    assign cmd_ready_o = (state == ST_RUN)
                       & (occ < CREDITS)
                       & fifo_in_ready;

    assign accept      = cmd_v_i & cmd_ready_o;
    assign init_done_o = (state == ST_RUN);

    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep;
        unique case (state)
            ST_INIT: begin
                if (sweep == SWEEP_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    sweep_nxt = sweep + 1'b1;
                end
            end
            ST_RUN: begin
                if (init_i) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_cnt == '0 && !rd_inflight) begin
                    state_nxt = ST_INIT;
                    sweep_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                sweep_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= ST_INIT;
            sweep       <= '0;
            rd_inflight <= 1'b0;
        end else begin
            state       <= state_nxt;
            sweep       <= sweep_nxt;
            rd_inflight <= accept & ~cmd_w_i;
        end
    end

    // Reset gates the strobe so nothing reaches the macro while held in reset.
    always_comb begin
        mem_v_o      = 1'b0;
        mem_w_o      = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        mem_w_mask_o = '0;
        if (reset_n_i) begin
            unique case (1'b1)
                (state == ST_INIT): begin
                    mem_v_o      = 1'b1;
                    mem_w_o      = 1'b1;
                    mem_addr_o   = sweep;
                    mem_w_mask_o = '1;
                end
                accept: begin
                    mem_v_o      = 1'b1;
                    mem_w_o      = cmd_w_i;
                    mem_addr_o   = cmd_addr_i;
                    mem_data_o   = cmd_data_i;
                    mem_w_mask_o = cmd_mask_i;
                end
                default: begin
                end
            endcase
        end
    end

    hard_mem_resp_fifo #(
        .DW(DW)
    ) u_resp_fifo (
        .clk      (clk_i),
        .rst_n    (reset_n_i),
        .in_v     (rd_inflight),
        .in_ready (fifo_in_ready),
        .in_data  (mem_data_i),
        .out_v    (resp_v_o),
        .out_ready(resp_ready_i),
        .out_data (resp_data_o),
        .count    (fifo_cnt)
    );

endmodule

// File: doc/hard_mem_1rw_requester.md
HARD_MEM_1RW_REQUESTER -- requirements
Module: hard_mem_1rw_requester

Interface
REQ-001 SHALL have parameter DW, default 64: data width; a multiple of 8.
REQ-002 SHALL have parameter AW, default 9: address width; depth is 2^AW.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk_i  in  1  sole clock; all state on rising edge.
REQ-005 reset_n_i  in  1  asynchronous, active-low reset.
REQ-006 cmd_v_i  in  1  command valid.
REQ-007 cmd_ready_o  out  1  command ready.
REQ-008 cmd_w_i  in  1  1 = write, 0 = read.
REQ-009 cmd_addr_i  in  AW  command address.
REQ-010 cmd_data_i  in  DW  write data.
REQ-011 cmd_mask_i  in  DW/8  byte write mask; bit k enables byte k.
REQ-012 resp_v_o  out  1  read response valid.
REQ-013 resp_ready_i  in  1  response consumer ready.
REQ-014 resp_data_o  out  DW  read data.
REQ-015 mem_v_o  out  1  memory access strobe.
REQ-016 mem_w_o  out  1  memory write enable.
REQ-017 mem_addr_o  out  AW  memory address.
REQ-018 mem_data_o  out  DW  memory write data.
REQ-019 mem_w_mask_o  out  DW/8  memory byte mask.
REQ-020 mem_data_i  in  DW  memory read data, valid the cycle after the read strobe.
REQ-021 init_i  in  1  request re-initialisation (zero sweep).
REQ-022 init_done_o  out  1  high while in RUN.

Function
REQ-023 SHALL implement states INIT, RUN and DRAIN.
REQ-024 INIT SHALL write zero with all-ones mask to addresses 0..2^AW-1, one per cycle, ascending; after the last address SHALL go to RUN.
REQ-025 cmd_ready_o SHALL be 1 only in RUN and when (fifo_cnt + rd_inflight - (resp_v_o & resp_ready_i)) < 2; this combinational path from resp_ready_i is intended.
REQ-026 In RUN, on cmd_v_i & cmd_ready_o, mem_* SHALL combinationally mirror the command in the same cycle; otherwise mem_v_o = 0.
REQ-027 mem_w_mask_o SHALL equal cmd_mask_i on writes and SHALL be don't-care on reads.
REQ-028 A read accepted in cycle N SHALL capture mem_data_i at the end of N+1 into a 2-entry response FIFO; resp_v_o no earlier than N+2.
REQ-029 Writes SHALL produce no response.
REQ-030 Responses SHALL return in command order, none dropped or duplicated under any resp_ready_i pattern.
REQ-031 resp_v_o/resp_data_o SHALL be driven from the FIFO head register and SHALL be held stable while resp_v_o & !resp_ready_i.
REQ-032 Sustained reads with resp_ready_i = 1 SHALL achieve one accept per cycle.
REQ-033 init_i = 1 in RUN SHALL move to DRAIN next cycle; a command accepted in that same cycle SHALL complete normally.
REQ-034 DRAIN SHALL deassert cmd_ready_o; when FIFO empty and rd_inflight = 0, SHALL enter INIT with sweep counter 0.
REQ-035 init_i in INIT or DRAIN SHALL be ignored.
REQ-036 The sweep counter SHALL not wrap into a second pass; terminal count 2^AW-1 ends INIT.

Reset
REQ-037 reset_n_i low SHALL immediately force state INIT, sweep counter 0, FIFO empty, rd_inflight 0.
REQ-038 During reset, cmd_ready_o, resp_v_o, mem_v_o, mem_w_o and init_done_o SHALL be 0, and mem_addr_o, mem_data_o and resp_data_o SHALL be 0.
REQ-039 Reset mid-sweep or mid-transfer SHALL discard all pending responses and restart the sweep from address 0.

Structure
REQ-040 Package hard_mem_req_pkg SHALL hold the state enum and the constant RESP_FIFO_DEPTH = 2.
REQ-041 The response FIFO SHALL be the sub-module hard_mem_resp_fifo (parameter DW, 2 entries, valid/ready on both sides).

Verification (DW=64, AW=9)
REQ-042 Release reset -> 512 writes to addresses 0..511 (data 0, mask 0xFF); init_done_o = 1 in cycle 512.
REQ-043 Write 0x0123456789ABCDEF to 0x010 with mask 0xFF, then read 0x010 -> resp_data_o = 0x0123456789ABCDEF with resp_v_o two cycles after the read accept.
REQ-044 Write all-ones to 0x010 with mask 0x0F, then read -> 0x01234567FFFFFFFF.
REQ-045 Back-to-back reads of 0x001..0x005 (preloaded 1..5) with resp_ready_i = 0 -> exactly 2 accepted, then cmd_ready_o = 0; raise resp_ready_i -> responses 1..5 in order, no gaps after the first.
REQ-046 init_i with 2 responses buffered -> DRAIN until both popped, then a 512-cycle sweep; subsequent read of 0x010 returns 0.
REQ-047 reset_n_i low during the sweep at address 37 -> all outputs 0 in the same cycle; after release the sweep restarts at address 0.
